// File: rtl/bram_result_reader_pkg.sv
`default_nettype none
// ============================================================================
//  Package     : bram_result_reader_pkg
//  Description : Shared state encodings, default widths and result-word
//                layout for the result BRAM reader.
//  Revision    : 1.0 - initial release
// ============================================================================
package bram_result_reader_pkg;

   // Control FSM encoding, shared with the data mover that fills the BRAM
   typedef enum logic [1:0] {
      S_IDLE = 2'b00,
      S_RUN  = 2'b01,
      S_DONE = 2'b10
   } state_t;

   // Default widths
   localparam int DEF_CNT_BIT  = 31;
   localparam int DEF_DWIDTH   = 32;
   localparam int DEF_AWIDTH   = 12;
   localparam int DEF_MEM_SIZE = 4096;

   // Each word packs one result per multiplier core, core 0 in the MSBs
   localparam int NUM_CORE    = 2;
   localparam int CORE_DWIDTH = DEF_DWIDTH / NUM_CORE;

   // Extract the result of one core from a packed result word
   function automatic logic [CORE_DWIDTH-1:0] core_result(
      input logic [DEF_DWIDTH-1:0] word,
      input int                    core
   );
      return word[DEF_DWIDTH-1-core*CORE_DWIDTH -: CORE_DWIDTH];
   endfunction

endpackage
`default_nettype wire

// File: rtl/bram_result_reader_rd_skid_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : bram_result_reader_rd_skid_fifo
//  Description : Two-entry FIFO holding BRAM read data that the downstream
//                stream has not yet accepted. Push and pop in the same cycle
//                leave the occupancy unchanged.
//  Revision    : 1.0 - initial release
// ============================================================================
module bram_result_reader_rd_skid_fifo #(
   parameter int DWIDTH = 32
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              push,
   input  logic [DWIDTH-1:0] push_data,
   input  logic              pop,
   output logic [1:0]        count,
   output logic [DWIDTH-1:0] head
);

   logic [DWIDTH-1:0] mem_q [2];
   logic [DWIDTH-1:0] mem_d [2];
   logic              wr_ptr_q, wr_ptr_d;
   logic              rd_ptr_q, rd_ptr_d;
   logic [1:0]        count_q,  count_d;

   // Next-state: write at the tail, advance the head, track occupancy
   always_comb begin
      mem_d    = mem_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (push) begin
         mem_d[wr_ptr_q] = push_data;
         wr_ptr_d        = ~wr_ptr_q;
      end
      if (pop) begin
         rd_ptr_d = ~rd_ptr_q;
      end
      case ({push, pop})
         2'b10:   count_d = count_q + 2'd1;
         2'b01:   count_d = count_q - 2'd1;
         default: count_d = count_q;
      endcase
   end

   // Storage and pointer registers; reset clears every entry
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         mem_q[0] <= '0;
         mem_q[1] <= '0;
         wr_ptr_q <= 1'b0;
         rd_ptr_q <= 1'b0;
         count_q  <= 2'd0;
      end else begin
         mem_q[0] <= mem_d[0];
         mem_q[1] <= mem_d[1];
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   assign count = count_q;
   assign head  = mem_q[rd_ptr_q];

endmodule
`default_nettype wire

// File: rtl/bram_result_reader.sv
`default_nettype none
// ============================================================================
//  Module      : bram_result_reader
//  Description : Drains the mul-core result BRAM through one BRAM port and
//                presents each word on a valid/ready stream, with run/idle/
//                done control. Reads are issued only while the skid buffer
//                plus the read in flight leaves room, so backpressure never
//                loses BRAM data. When the buffer is empty, the word arriving
//                from the BRAM is presented directly so that the stream runs
//                one word per cycle with two cycles of start latency.
//  Options     : BRAM_READER_LAST_EN - adds o_m_last on the final word.
//  Revision    : 1.0 - initial release
// ============================================================================
module bram_result_reader
   import bram_result_reader_pkg::*;
#(
   parameter int CNT_BIT  = DEF_CNT_BIT,
   parameter int DWIDTH   = DEF_DWIDTH,
   parameter int AWIDTH   = DEF_AWIDTH,
   parameter int MEM_SIZE = DEF_MEM_SIZE
) (
   input  logic               clk,
   input  logic               reset_n,
   input  logic               i_run,
   input  logic [CNT_BIT-1:0] i_num_cnt,
   output logic               o_idle,
   output logic               o_read,
   output logic               o_done,
   output logic [AWIDTH-1:0]  addr_b,
   output logic               ce_b,
   output logic               we_b,
   input  logic [DWIDTH-1:0]  q_b,
   output logic [DWIDTH-1:0]  d_b,
   output logic               o_m_valid,
   input  logic               i_m_ready,
`ifdef BRAM_READER_LAST_EN
   output logic               o_m_last,
`endif
   output logic [DWIDTH-1:0]  o_m_data
);

   localparam logic [CNT_BIT-1:0] CNT_ONE = CNT_BIT'(1);

   generate
      if (MEM_SIZE != (1 << AWIDTH) || CNT_BIT < AWIDTH) begin : g_param_check
         $error("bram_result_reader: MEM_SIZE must be 2**AWIDTH and CNT_BIT >= AWIDTH");
      end
   endgenerate

   state_t             state_q,    state_d;
   logic [CNT_BIT-1:0] num_cnt_q,  num_cnt_d;
   logic [CNT_BIT-1:0] rd_cnt_q,   rd_cnt_d;
   logic [CNT_BIT-1:0] out_cnt_q,  out_cnt_d;
   logic               inflight_q, inflight_d;

   logic [1:0]         buf_cnt;
   logic [DWIDTH-1:0]  buf_head;
   logic               buf_empty;
   logic               pop;
   logic               fifo_push;
   logic               fifo_pop;
   logic               issue;
   logic               is_last;
   logic [2:0]         occ;

   // Stream side: buffer head first, otherwise the word landing from the BRAM
   always_comb begin
      buf_empty = (buf_cnt == 2'd0);
      o_m_valid = !buf_empty || inflight_q;
      if (!buf_empty) begin
         o_m_data = buf_head;
      end else if (inflight_q) begin
         o_m_data = q_b;
      end else begin
         o_m_data = '0;
      end
      pop       = o_m_valid && i_m_ready;
      // A landing word accepted straight through never enters the buffer
      fifo_push = inflight_q && !(buf_empty && pop);
      fifo_pop  = pop && !buf_empty;
      is_last   = (out_cnt_q == num_cnt_q - CNT_ONE);
      // Words held after this cycle, before any new read is issued
      occ       = {1'b0, buf_cnt} + {2'b00, inflight_q} - {2'b00, pop};
      issue     = (state_q == S_RUN) && (rd_cnt_q < num_cnt_q) && (occ < 3'd2);
   end

   // Control FSM and transfer counters
   always_comb begin
      state_d    = state_q;
      num_cnt_d  = num_cnt_q;
      rd_cnt_d   = rd_cnt_q;
      out_cnt_d  = out_cnt_q;
      inflight_d = issue;
      case (state_q)
         S_IDLE: begin
            if (i_run) begin
               state_d   = S_RUN;
               num_cnt_d = i_num_cnt;
               rd_cnt_d  = '0;
               out_cnt_d = '0;
            end
         end
         S_RUN: begin
            if (issue) begin
               rd_cnt_d = rd_cnt_q + CNT_ONE;
            end
            if (pop) begin
               out_cnt_d = out_cnt_q + CNT_ONE;
            end
            if ((num_cnt_q == '0) || (pop && is_last)) begin
               state_d = S_DONE;
            end
         end
         S_DONE: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // State and counter registers; reset aborts any transfer in progress
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q    <= S_IDLE;
         num_cnt_q  <= '0;
         rd_cnt_q   <= '0;
         out_cnt_q  <= '0;
         inflight_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         num_cnt_q  <= num_cnt_d;
         rd_cnt_q   <= rd_cnt_d;
         out_cnt_q  <= out_cnt_d;
         inflight_q <= inflight_d;
      end
   end

   bram_result_reader_rd_skid_fifo #(
      .DWIDTH    (DWIDTH)
   ) u_rd_skid_fifo (
      .clk       (clk),
      .reset_n   (reset_n),
      .push      (fifo_push),
      .push_data (q_b),
      .pop       (fifo_pop),
      .count     (buf_cnt),
      .head      (buf_head)
   );

   assign o_idle = (state_q == S_IDLE);
   assign o_read = (state_q == S_RUN);
   assign o_done = (state_q == S_DONE);
   assign ce_b   = issue;
   assign addr_b = rd_cnt_q[AWIDTH-1:0];
   assign we_b   = 1'b0;
   assign d_b    = '0;

`ifdef BRAM_READER_LAST_EN
   assign o_m_last = o_m_valid && (state_q == S_RUN) && is_last;
`endif

endmodule
`default_nettype wire
